// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder (a + b + cin -> sum, cout) split into CHUNKS
// pipeline stages. Each stage is a WIDTH/CHUNKS-bit ripple slice, and the carry is
// registered between stages. Valid/ready handshakes sit on both sides. When the
// output is held, the whole pipeline stalls.
//
// Optional feature macro: ADDER_OVF_FLAG_EN
//   When defined, this adds the 'ovf' output (signed overflow, aligned with sum).
//   The operand sign bits are piped along with the data to produce it.

module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int CHUNKS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_FLAG_EN
   ,output logic             ovf
`endif
);

    // Bits added by each stage
    localparam int C = WIDTH / CHUNKS;

    // Global advance: a held, un-taken result freezes every stage at once
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    genvar k;
    generate
        for (k = 0; k < CHUNKS; k++) begin : g_stage
            // Operand bits still to be added on entry, and sum bits complete on exit
            localparam int SRC_W  = WIDTH - k * C;
            localparam int DONE_W = (k + 1) * C;

            logic [SRC_W-1:0]  src_a;
            logic [SRC_W-1:0]  src_b;
            logic              src_carry;
            logic              src_valid;
            logic [C:0]        slice;
            logic [DONE_W-1:0] next_sum;

            logic              valid_q;
            logic              carry_q;
            logic [DONE_W-1:0] sum_q;

`ifdef ADDER_OVF_FLAG_EN
            logic              src_a_msb;
            logic              src_b_msb;
`endif

            if (k == 0) begin : g_src
                // The first stage takes its operands straight from the input port
                assign src_a     = a;
                assign src_b     = b;
                assign src_carry = cin;
                assign src_valid = in_valid;
                assign next_sum  = slice[C-1:0];
`ifdef ADDER_OVF_FLAG_EN
                assign src_a_msb = a[WIDTH-1];
                assign src_b_msb = b[WIDTH-1];
`endif
            end else begin : g_src
                // Later stages take the remaining operand bits and the partial sum from the previous stage
                assign src_a     = g_stage[k-1].g_rem.rem_a_q;
                assign src_b     = g_stage[k-1].g_rem.rem_b_q;
                assign src_carry = g_stage[k-1].carry_q;
                assign src_valid = g_stage[k-1].valid_q;
                assign next_sum  = {slice[C-1:0], g_stage[k-1].sum_q};
`ifdef ADDER_OVF_FLAG_EN
                assign src_a_msb = g_stage[k-1].g_rem.a_msb_q;
                assign src_b_msb = g_stage[k-1].g_rem.b_msb_q;
`endif
            end

            // The C+1-bit slice sum; its top bit is the carry into the next stage
            assign slice = {1'b0, src_a[C-1:0]} + {1'b0, src_b[C-1:0]} + {{C{1'b0}}, src_carry};

            // Stage register: valid bit, completed low sum bits and outgoing carry, held on stall
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    sum_q   <= '0;
                end else if (advance) begin
                    valid_q <= src_valid;
                    carry_q <= slice[C];
                    sum_q   <= next_sum;
                end
            end

            if (k < CHUNKS - 1) begin : g_rem
                logic [SRC_W-C-1:0] rem_a_q;
                logic [SRC_W-C-1:0] rem_b_q;
`ifdef ADDER_OVF_FLAG_EN
                logic               a_msb_q;
                logic               b_msb_q;
`endif

                // Carry the not-yet-added upper operand chunks along with this stage
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        rem_a_q <= '0;
                        rem_b_q <= '0;
                    end else if (advance) begin
                        rem_a_q <= src_a[SRC_W-1:C];
                        rem_b_q <= src_b[SRC_W-1:C];
                    end
                end

`ifdef ADDER_OVF_FLAG_EN
                // Pipe the original operand sign bits so overflow can be judged at the end
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_msb_q <= 1'b0;
                        b_msb_q <= 1'b0;
                    end else if (advance) begin
                        a_msb_q <= src_a_msb;
                        b_msb_q <= src_b_msb;
                    end
                end
`endif
            end
        end
    endgenerate

    // The last stage register is the output register
    assign out_valid = g_stage[CHUNKS-1].valid_q;
    assign sum       = g_stage[CHUNKS-1].sum_q;
    assign cout      = g_stage[CHUNKS-1].carry_q;

`ifdef ADDER_OVF_FLAG_EN
    logic ovf_next;
    assign ovf_next = (g_stage[CHUNKS-1].src_a_msb == g_stage[CHUNKS-1].src_b_msb) &&
                      (g_stage[CHUNKS-1].next_sum[WIDTH-1] != g_stage[CHUNKS-1].src_a_msb);

    // Overflow flag registered alongside the final sum so the two stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (advance) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of pipelined_adder against an
// arithmetic reference model with a queue of expected results.
// Optional feature macro: ADDER_OVF_FLAG_EN (adds the ovf checks).

module tb_pipelined_adder;

    localparam int WIDTH  = 8;
    localparam int CHUNKS = 2;

    logic             clk = 1'b0;
    logic             rstN;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic             cinIn;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] sumOut;
    logic             coutOut;
`ifdef ADDER_OVF_FLAG_EN
    logic             ovfOut;
`endif

    int               checkCount = 0;
    int               failCount  = 0;
    logic [WIDTH+1:0] expQueue[$];
    logic [WIDTH-1:0] resultLog[$];
    logic [WIDTH-1:0] lastSum;
    logic             lastCout;
    logic             lastOvf;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .CHUNKS (CHUNKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (aIn),
        .b         (bIn),
        .cin       (cinIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sumOut),
        .cout      (coutOut)
`ifdef ADDER_OVF_FLAG_EN
       ,.ovf       (ovfOut)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned and signed arithmetic, packed as {ovf, cout, sum}
    function automatic logic [WIDTH+1:0] refModel(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic c);
        int unsigned total;
        int          signedTotal;
        int          lim;
        logic        o;
        total       = int'(x) + int'(y) + int'(c);
        signedTotal = int'($signed(x)) + int'($signed(y)) + int'(c);
        lim         = 1 << (WIDTH - 1);
        o           = (signedTotal >= lim) || (signedTotal < -lim);
`ifndef ADDER_OVF_FLAG_EN
        o = 1'b0;
`endif
        return {o, total[WIDTH], total[WIDTH-1:0]};
    endfunction

    // Current DUT result packed like the reference
    function automatic logic [WIDTH+1:0] observed();
        logic o;
        o = 1'b0;
`ifdef ADDER_OVF_FLAG_EN
        o = ovfOut;
`endif
        return {o, coutOut, sumOut};
    endfunction

    // Single comparison point: counts and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then score handshakes before the next rising edge
    task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                 input logic ic, input logic ordy, output logic accepted);
        logic [WIDTH+1:0] expVal;
        @(negedge clk);
        inValid  = iv;
        aIn      = ia;
        bIn      = ib;
        cinIn    = ic;
        outReady = ordy;
        #1;
        if (ordy) checkOutput("in_ready_when_out_ready", inReady, 1);
        if (outValid) begin
            if (expQueue.size() == 0) begin
                checkOutput("spurious_out_valid", outValid, 0);
            end else if (ordy) begin
                expVal = expQueue.pop_front();
                checkOutput("result", observed(), expVal);
                lastSum  = sumOut;
                lastCout = coutOut;
                lastOvf  = observed() >> (WIDTH + 1);
                resultLog.push_back(sumOut);
            end else begin
                checkOutput("hold_stable", observed(), expQueue[0]);
            end
        end
        accepted = iv && inReady;
        if (accepted) expQueue.push_back(refModel(ia, ib, ic));
    endtask

    // Send one operation into an empty pipeline and check its exact latency
    task automatic runSingle(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        logic acc;
        applyStimulus(1'b1, x, y, c, 1'b1, acc);
        checkOutput("single_accept", acc, 1);
        for (int s = 1; s <= CHUNKS; s++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc);
            checkOutput("latency_out_valid", outValid, (s == CHUNKS) ? 1 : 0);
        end
    endtask

    // Keep the output ready until every expected result has come out, bounded
    task automatic drain();
        logic acc;
        for (int i = 0; i < 50 && expQueue.size() > 0; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc);
        end
        checkOutput("drain_empty", expQueue.size(), 0);
    endtask

    initial begin
        logic             acc;
        logic [WIDTH-1:0] opA[4];
        logic [WIDTH-1:0] opB[4];
        logic [WIDTH-1:0] expOut[4];
        int               idx;
        logic             ordy;

        // Reset state
        rstN = 1'b0; inValid = 1'b0; aIn = '0; bIn = '0; cinIn = 1'b0; outReady = 1'b1;
        #12;
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_sum", sumOut, 0);
        checkOutput("reset_cout", coutOut, 0);
        checkOutput("reset_in_ready", inReady, 1);
        @(negedge clk);
        rstN = 1'b1;

        // Directed single operations
        runSingle(8'h01, 8'h01, 1'b0);
        checkOutput("ex1_sum", lastSum, 8'h02);
        checkOutput("ex1_cout", lastCout, 0);
        runSingle(8'h0F, 8'h01, 1'b0);
        checkOutput("ex2_sum", lastSum, 8'h10);
        checkOutput("ex2_cout", lastCout, 0);
        runSingle(8'hFF, 8'h01, 1'b0);
        checkOutput("ex3_sum", lastSum, 8'h00);
        checkOutput("ex3_cout", lastCout, 1);
        runSingle(8'h02, 8'h02, 1'b1);
        checkOutput("ex4_sum", lastSum, 8'h05);

        // Back-to-back with a 3-cycle output stall after the first result
        opA    = '{8'h01, 8'h02, 8'h09, 8'h02};
        opB    = '{8'h01, 8'h01, 8'h07, 8'h02};
        expOut = '{8'h02, 8'h03, 8'h10, 8'h04};
        resultLog.delete();
        idx = 0;
        for (int slot = 0; slot < 12; slot++) begin
            ordy = !(slot >= 2 && slot <= 4);
            if (idx < 4) applyStimulus(1'b1, opA[idx], opB[idx], 1'b0, ordy, acc);
            else         applyStimulus(1'b0, '0, '0, 1'b0, ordy, acc);
            if (acc) idx++;
            if (!ordy) begin
                checkOutput("stall_out_valid", outValid, 1);
                checkOutput("stall_in_ready", inReady, 0);
            end
        end
        checkOutput("b2b_count", resultLog.size(), 4);
        for (int i = 0; i < 4 && i < resultLog.size(); i++) begin
            checkOutput("b2b_order", resultLog[i], expOut[i]);
        end

        // Reset with two operations in flight
        applyStimulus(1'b1, 8'h10, 8'h20, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 8'h03, 8'h04, 1'b0, 1'b1, acc);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("pre_reset_valid", outValid, 1);
        rstN = 1'b0;
        #1;
        checkOutput("midreset_out_valid", outValid, 0);
        checkOutput("midreset_sum", sumOut, 0);
        checkOutput("midreset_cout", coutOut, 0);
        expQueue.delete();
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, acc);
            checkOutput("post_reset_idle", outValid, 0);
        end
        runSingle(8'h21, 8'h12, 1'b1);
        checkOutput("post_reset_sum", lastSum, 8'h34);

`ifdef ADDER_OVF_FLAG_EN
        runSingle(8'h7F, 8'h01, 1'b0);
        checkOutput("ovf1_sum", lastSum, 8'h80);
        checkOutput("ovf1_flag", lastOvf, 1);
        checkOutput("ovf1_cout", lastCout, 0);
        runSingle(8'h80, 8'hFF, 1'b0);
        checkOutput("ovf2_sum", lastSum, 8'h7F);
        checkOutput("ovf2_flag", lastOvf, 1);
        checkOutput("ovf2_cout", lastCout, 1);
        runSingle(8'h05, 8'h03, 1'b0);
        checkOutput("ovf3_flag", lastOvf, 0);
`endif

        // Randomized traffic with random bubbles and back-pressure
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, WIDTH'($urandom), WIDTH'($urandom),
                          1'($urandom), $urandom_range(0, 9) < 7, acc);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
